// File: rtl/rf_pkg.sv
// Shared types and constants for the register-file write arbiter slice.
package rf_pkg;

  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 5;
  localparam int NUM_REGS = 32;

  localparam logic [ADDR_W-1:0] ZERO_REG = 5'd0;

  // One writeback request as seen by the arbiter. The destination field is
  // called 'dest' because 'reg' is a reserved word.
  typedef struct packed {
    logic              valid;
    logic [ADDR_W-1:0] dest;
    logic [DATA_W-1:0] data;
  } wb_req_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter. The pointer names the requester that wins the
// next contended cycle and is moved to the loser after every contention.
module rr_arb2 (
  input  logic       clk,
  input  logic       rstn,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  logic r_ptr;

  // Lone requester wins outright; on contention the pointer decides.
  always_comb begin
    gnt = 2'b00;
    if (rstn) begin
      if (req == 2'b11) begin
        gnt = r_ptr ? 2'b10 : 2'b01;
      end else begin
        gnt = req;
      end
    end
  end

  // After a contended cycle the loser becomes the favoured requester.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_ptr <= 1'b0;
    end else if (req == 2'b11) begin
      r_ptr <= gnt[0];
    end
  end

endmodule

// File: rtl/rf_write_arbiter.sv
// Shares the single register-file write port between the ALU and MEM
// writeback paths, registers the winner into a one-entry commit stage and
// forwards the pending write to the read ports.
module rf_write_arbiter
  import rf_pkg::*;
#(
  parameter int DATA_W = rf_pkg::DATA_W,
  parameter int ADDR_W = rf_pkg::ADDR_W,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [ADDR_W-1:0] req0_reg,
  input  logic [DATA_W-1:0] req0_data,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [ADDR_W-1:0] req1_reg,
  input  logic [DATA_W-1:0] req1_data,
  output logic              rf_reg_write,
  output logic [ADDR_W-1:0] rf_write_reg,
  output logic [DATA_W-1:0] rf_write_data,
  input  logic [ADDR_W-1:0] rd_reg_1,
  input  logic [ADDR_W-1:0] rd_reg_2,
  output logic              fwd_hit_1,
  output logic              fwd_hit_2,
  output logic [DATA_W-1:0] fwd_data,
  output logic [CNT_W-1:0]  wr_count
);

  wb_req_t           w_req0;
  wb_req_t           w_req1;
  wb_req_t           w_win;
  logic [1:0]        w_gnt;
  logic              w_commit;

  logic              r_out_valid;
  logic [ADDR_W-1:0] r_out_reg;
  logic [DATA_W-1:0] r_out_data;
  logic [CNT_W-1:0]  r_count;

  assign w_req0 = '{valid: req0_valid, dest: req0_reg, data: req0_data};
  assign w_req1 = '{valid: req1_valid, dest: req1_reg, data: req1_data};

  rr_arb2 u_arb (
    .clk  (clk),
    .rstn (rstn),
    .req  ({req1_valid, req0_valid}),
    .gnt  (w_gnt)
  );

  // The commit stage drains every cycle, so a grant is always an acceptance.
  assign req0_ready = w_gnt[0];
  assign req1_ready = w_gnt[1];

  // Select the granted request; all-zero when nobody is granted.
  always_comb begin
    w_win = '0;
    if (w_gnt[1]) begin
      w_win = w_req1;
    end else if (w_gnt[0]) begin
      w_win = w_req0;
    end
  end

  // Writes to register 0 are accepted but dropped here.
  assign w_commit = w_win.valid && (w_win.dest != ZERO_REG);

  // Commit stage: a reset discards whatever was pending.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_out_valid <= 1'b0;
      r_out_reg   <= '0;
      r_out_data  <= '0;
    end else begin
      r_out_valid <= w_commit;
      r_out_reg   <= w_win.dest;
      r_out_data  <= w_win.data;
    end
  end

  // Count every latched commit, wrapping naturally at the counter width.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_count <= '0;
    end else if (w_commit) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  assign rf_reg_write  = r_out_valid;
  assign rf_write_reg  = r_out_reg;
  assign rf_write_data = r_out_data;

  assign fwd_hit_1 = r_out_valid && (r_out_reg == rd_reg_1) && (rd_reg_1 != ZERO_REG);
  assign fwd_hit_2 = r_out_valid && (r_out_reg == rd_reg_2) && (rd_reg_2 != ZERO_REG);
  assign fwd_data  = r_out_data;

  assign wr_count = r_count;

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Directed bench for rf_write_arbiter: a vector table plus a couple of
// hand-written sequences for back-to-back contention and counter wrap.
module tb_rf_write_arbiter;

  logic        clk = 1'b0;
  logic        rstn;
  logic        req0_valid, req1_valid;
  logic        req0_ready, req1_ready;
  logic [4:0]  req0_reg, req1_reg;
  logic [31:0] req0_data, req1_data;
  logic        rf_reg_write;
  logic [4:0]  rf_write_reg;
  logic [31:0] rf_write_data;
  logic [4:0]  rd_reg_1, rd_reg_2;
  logic        fwd_hit_1, fwd_hit_2;
  logic [31:0] fwd_data;
  logic [15:0] wr_count;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        rstn;
    logic        v0;
    logic [4:0]  r0;
    logic [31:0] d0;
    logic        v1;
    logic [4:0]  r1;
    logic [31:0] d1;
    logic [4:0]  rd1;
    logic [4:0]  rd2;
    logic        rdy0;
    logic        rdy1;
    logic        we;
    logic [4:0]  wreg;
    logic [31:0] wdata;
    logic        hit1;
    logic        hit2;
    logic [15:0] cnt;
  } vec_t;

  vec_t vecs[$];

  rf_write_arbiter #(.DATA_W(32), .ADDR_W(5), .CNT_W(16)) dut (
    .clk           (clk),
    .rstn          (rstn),
    .req0_valid    (req0_valid),
    .req0_ready    (req0_ready),
    .req0_reg      (req0_reg),
    .req0_data     (req0_data),
    .req1_valid    (req1_valid),
    .req1_ready    (req1_ready),
    .req1_reg      (req1_reg),
    .req1_data     (req1_data),
    .rf_reg_write  (rf_reg_write),
    .rf_write_reg  (rf_write_reg),
    .rf_write_data (rf_write_data),
    .rd_reg_1      (rd_reg_1),
    .rd_reg_2      (rd_reg_2),
    .fwd_hit_1     (fwd_hit_1),
    .fwd_hit_2     (fwd_hit_2),
    .fwd_data      (fwd_data),
    .wr_count      (wr_count)
  );

  always #5 clk = ~clk;

  task automatic addVec(input logic rs,
                        input logic v0, input logic [4:0] r0, input logic [31:0] d0,
                        input logic v1, input logic [4:0] r1, input logic [31:0] d1,
                        input logic [4:0] rd1, input logic [4:0] rd2,
                        input logic rdy0, input logic rdy1, input logic we,
                        input logic [4:0] wreg, input logic [31:0] wdata,
                        input logic hit1, input logic hit2, input logic [15:0] cnt);
    vec_t v;
    v.rstn = rs; v.v0 = v0; v.r0 = r0; v.d0 = d0;
    v.v1 = v1; v.r1 = r1; v.d1 = d1; v.rd1 = rd1; v.rd2 = rd2;
    v.rdy0 = rdy0; v.rdy1 = rdy1; v.we = we; v.wreg = wreg; v.wdata = wdata;
    v.hit1 = hit1; v.hit2 = hit2; v.cnt = cnt;
    vecs.push_back(v);
  endtask

  task automatic applyStimulus(input vec_t v);
    rstn       = v.rstn;
    req0_valid = v.v0;
    req0_reg   = v.r0;
    req0_data  = v.d0;
    req1_valid = v.v1;
    req1_reg   = v.r1;
    req1_data  = v.d1;
    rd_reg_1   = v.rd1;
    rd_reg_2   = v.rd2;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic checkVec(input int idx, input vec_t v);
    string tag;
    tag = $sformatf("vec%0d", idx);
    checkOutput({tag, ".req0_ready"},    32'(req0_ready),    32'(v.rdy0));
    checkOutput({tag, ".req1_ready"},    32'(req1_ready),    32'(v.rdy1));
    checkOutput({tag, ".rf_reg_write"},  32'(rf_reg_write),  32'(v.we));
    checkOutput({tag, ".rf_write_reg"},  32'(rf_write_reg),  32'(v.wreg));
    checkOutput({tag, ".rf_write_data"}, rf_write_data,      v.wdata);
    checkOutput({tag, ".fwd_hit_1"},     32'(fwd_hit_1),     32'(v.hit1));
    checkOutput({tag, ".fwd_hit_2"},     32'(fwd_hit_2),     32'(v.hit2));
    checkOutput({tag, ".fwd_data"},      fwd_data,           v.wdata);
    checkOutput({tag, ".wr_count"},      32'(wr_count),      32'(v.cnt));
  endtask

  initial begin
    rstn = 1'b0;
    req0_valid = 1'b0; req0_reg = '0; req0_data = '0;
    req1_valid = 1'b0; req1_reg = '0; req1_data = '0;
    rd_reg_1 = '0; rd_reg_2 = '0;

    // rs  v0 r0  d0            v1 r1  d1      rd1 rd2 | rdy0 rdy1 we wreg wdata         h1 h2 cnt
    // reset for three cycles, then idle
    addVec(0, 0, 0, 32'h0,        0, 0, 32'h0,   0, 0,   0, 0, 0, 0, 32'h0,        0, 0, 0);
    addVec(0, 0, 0, 32'h0,        0, 0, 32'h0,   0, 0,   0, 0, 0, 0, 32'h0,        0, 0, 0);
    addVec(0, 0, 0, 32'h0,        0, 0, 32'h0,   0, 0,   0, 0, 0, 0, 32'h0,        0, 0, 0);
    addVec(1, 0, 0, 32'h0,        0, 0, 32'h0,   0, 0,   0, 0, 0, 0, 32'h0,        0, 0, 0);
    addVec(1, 0, 0, 32'h0,        0, 0, 32'h0,   0, 0,   0, 0, 0, 0, 32'h0,        0, 0, 0);
    // single requester, committed one cycle later and forwarded on port 1
    addVec(1, 1, 5, 32'hDEADBEEF, 0, 0, 32'h0,   0, 0,   1, 0, 0, 0, 32'h0,        0, 0, 0);
    addVec(1, 0, 0, 32'h0,        0, 0, 32'h0,   5, 0,   0, 0, 1, 5, 32'hDEADBEEF, 1, 0, 1);
    // contention: req0 first, req1 next; then req1 favoured
    addVec(1, 1, 3, 32'h11,       1, 4, 32'h22,  0, 0,   1, 0, 0, 0, 32'h0,        0, 0, 1);
    addVec(1, 0, 0, 32'h0,        1, 4, 32'h22,  0, 0,   0, 1, 1, 3, 32'h11,       0, 0, 2);
    addVec(1, 1, 3, 32'h11,       1, 4, 32'h22,  0, 0,   0, 1, 1, 4, 32'h22,       0, 0, 3);
    addVec(1, 1, 3, 32'h11,       0, 0, 32'h0,   0, 0,   1, 0, 1, 4, 32'h22,       0, 0, 4);
    addVec(1, 0, 0, 32'h0,        0, 0, 32'h0,   0, 0,   0, 0, 1, 3, 32'h11,       0, 0, 5);
    // register 0: accepted, data latched but never written or counted
    addVec(1, 0, 0, 32'h0,        1, 0, 32'hFF,  0, 0,   0, 1, 0, 0, 32'h0,        0, 0, 5);
    addVec(1, 0, 0, 32'h0,        0, 0, 32'h0,   0, 0,   0, 0, 0, 0, 32'hFF,       0, 0, 5);
    // forwarding on port 1, then port 2 (port 1 reading 0 / other reg)
    addVec(1, 1, 9, 32'h55,       0, 0, 32'h0,   0, 0,   1, 0, 0, 0, 32'h0,        0, 0, 5);
    addVec(1, 0, 0, 32'h0,        0, 0, 32'h0,   9, 0,   0, 0, 1, 9, 32'h55,       1, 0, 6);
    addVec(1, 1, 9, 32'h66,       0, 0, 32'h0,   9, 9,   1, 0, 0, 0, 32'h0,        0, 0, 6);
    addVec(1, 0, 0, 32'h0,        0, 0, 32'h0,   3, 9,   0, 0, 1, 9, 32'h66,       0, 1, 7);
    // same-register race: A then B on consecutive cycles
    addVec(1, 1, 7, 32'hA,        1, 7, 32'hB,   0, 0,   1, 0, 0, 0, 32'h0,        0, 0, 7);
    addVec(1, 0, 0, 32'h0,        1, 7, 32'hB,   0, 0,   0, 1, 1, 7, 32'hA,        0, 0, 8);
    // pointer now favours req1; accept reg 12 then reset before it can commit
    addVec(1, 1, 12, 32'hC,       0, 0, 32'h0,   0, 0,   1, 0, 1, 7, 32'hB,        0, 0, 9);
    addVec(0, 1, 12, 32'hC,       0, 0, 32'h0,   0, 0,   0, 0, 0, 0, 32'h0,        0, 0, 0);
    // after reset the pointer favours req0 again
    addVec(1, 1, 1, 32'h1,        1, 2, 32'h2,   0, 0,   1, 0, 0, 0, 32'h0,        0, 0, 0);
    addVec(1, 0, 0, 32'h0,        1, 2, 32'h2,   2, 1,   0, 1, 1, 1, 32'h1,        0, 1, 1);
    addVec(1, 0, 0, 32'h0,        0, 0, 32'h0,   2, 2,   0, 0, 1, 2, 32'h2,        1, 1, 2);

    @(negedge clk);
    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i]);
      #1;
      checkVec(i, vecs[i]);
      @(negedge clk);
    end

    // Both requesters held valid without dropping: grants alternate every cycle.
    rstn = 1'b0;
    req0_valid = 1'b1; req0_reg = 5'd3; req0_data = 32'h33;
    req1_valid = 1'b1; req1_reg = 5'd4; req1_data = 32'h44;
    rd_reg_1 = '0; rd_reg_2 = '0;
    @(negedge clk);
    rstn = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      checkOutput($sformatf("alt%0d.req0_ready", k), 32'(req0_ready), 32'((k % 2) == 0));
      checkOutput($sformatf("alt%0d.req1_ready", k), 32'(req1_ready), 32'((k % 2) == 1));
      checkOutput($sformatf("alt%0d.rf_write_reg", k), 32'(rf_write_reg),
                  (k == 0) ? 32'd0 : (((k % 2) == 1) ? 32'd3 : 32'd4));
      @(negedge clk);
    end

    // Counter wrap: one commit per cycle for 2^16 cycles.
    rstn = 1'b0;
    req0_valid = 1'b1; req0_reg = 5'd1; req0_data = 32'h1234;
    req1_valid = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    repeat (65535) @(posedge clk);
    @(negedge clk);
    checkOutput("wrap.wr_count_max", 32'(wr_count), 32'h0000FFFF);
    @(negedge clk);
    checkOutput("wrap.wr_count_zero", 32'(wr_count), 32'h0);
    checkOutput("wrap.rf_reg_write", 32'(rf_reg_write), 32'h1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
